rv32_instr_responder: RTL and testbench



---
 rtl/rv32_instr_responder.sv | 135 +++++++++++++
 tb/tb_rv32_instr_responder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_instr_responder.sv
// Instruction-bus responder: decode, one-entry hold register, wait-state fill.
// Optional counters via `define RV32_INSTR_RESP_STATS_EN.
module rv32_instr_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int SIZE_WORDS = 1024,
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic instr_read_in,
  input  logic [31:0] instr_address_in,
  input  logic invalidate_in,
  output logic [31:0] instr_read_value_out,
  output logic instr_fault_out,
  output logic instr_stall_out,
  output logic mem_en_out,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_out,
  input  logic [31:0] mem_rdata_in
`ifdef RV32_INSTR_RESP_STATS_EN
  ,
  output logic [31:0] stat_hits_out,
  output logic [31:0] stat_misses_out,
  output logic [31:0] stat_faults_out
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [32:0] REGION_BYTES = 33'(SIZE_WORDS) * 33'd4;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t state, state_next;
  logic [31:0] hold_addr;
  logic [31:0] hold_data;
  logic hold_valid;
  logic [3:0] wait_cnt;
  logic [31:0] pend_addr;
  logic pend_kill;

  logic [32:0] offset;
  logic fault;
  logic hit;
  logic start;

  // 33-bit offset so the last word of a top-of-space region cannot wrap
  assign offset = {1'b0, instr_address_in} - {1'b0, BASE_ADDR};
  assign fault = (instr_address_in[1:0] != 2'b00)
               | (instr_address_in < BASE_ADDR)
               | (offset >= REGION_BYTES);
  assign hit = hold_valid && (instr_address_in == hold_addr);
  assign mem_addr_out = offset[MEM_ADDR_WIDTH+1:2];

  always_comb begin
    instr_read_value_out = NOP;
    instr_fault_out = 1'b0;
    instr_stall_out = 1'b0;
    mem_en_out = 1'b0;
    start = 1'b0;
    state_next = state;
    if (!reset_n) begin
      instr_stall_out = instr_read_in;
    end else if (instr_read_in) begin
      if (fault) begin
        instr_fault_out = 1'b1;
      end else if (hit) begin
        instr_read_value_out = hold_data;
      end else begin
        instr_stall_out = 1'b1;
        if (state == IDLE) begin
          mem_en_out = 1'b1;
          start = 1'b1;
        end
      end
    end
    unique case (state)
      IDLE: if (start) state_next = WAIT;
      WAIT: if (wait_cnt == 4'd0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      hold_addr <= 32'h0;
      hold_data <= NOP;
      hold_valid <= 1'b0;
      wait_cnt <= 4'd0;
      pend_addr <= 32'h0;
      pend_kill <= 1'b0;
    end else begin
      state <= state_next;
      if (start) begin
        pend_addr <= instr_address_in;
        wait_cnt <= 4'(WAIT_STATES);
        pend_kill <= 1'b0;
      end
      if (state == WAIT) begin
        if (wait_cnt == 4'd0) begin
          hold_data <= mem_rdata_in;
          hold_addr <= pend_addr;
          hold_valid <= !pend_kill;
          pend_kill <= 1'b0;
        end else begin
          wait_cnt <= wait_cnt - 4'd1;
          if (invalidate_in) pend_kill <= 1'b1;
        end
      end
      // Last assignment wins, so fence.i beats a same-cycle fill
      if (invalidate_in) hold_valid <= 1'b0;
    end
  end

`ifdef RV32_INSTR_RESP_STATS_EN
  logic hit_served;
  assign hit_served = reset_n && instr_read_in && !fault && hit;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stat_hits_out <= 32'h0;
      stat_misses_out <= 32'h0;
      stat_faults_out <= 32'h0;
    end else begin
      if (hit_served && stat_hits_out != 32'hFFFF_FFFF)
        stat_hits_out <= stat_hits_out + 32'd1;
      if (mem_en_out && stat_misses_out != 32'hFFFF_FFFF)
        stat_misses_out <= stat_misses_out + 32'd1;
      if (instr_fault_out && stat_faults_out != 32'hFFFF_FFFF)
        stat_faults_out <= stat_faults_out + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rv32_instr_responder.sv
// Scoreboard bench for rv32_instr_responder: transaction-level model,
// directed scenarios then randomized traffic.
module tb_rv32_instr_responder;

  localparam int WS = 1;
  localparam int SIZE = 1024;
  localparam int AW = 10;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset_n;
  logic instr_read_in;
  logic [31:0] instr_address_in;
  logic invalidate_in;
  logic [31:0] instr_read_value_out;
  logic instr_fault_out;
  logic instr_stall_out;
  logic mem_en_out;
  logic [AW-1:0] mem_addr_out;
  logic [31:0] mem_rdata_in;
`ifdef RV32_INSTR_RESP_STATS_EN
  logic [31:0] stat_hits_out, stat_misses_out, stat_faults_out;
`endif

  always #5 clk = ~clk;

  rv32_instr_responder #(
    .BASE_ADDR(BASE), .SIZE_WORDS(SIZE),
    .MEM_ADDR_WIDTH(AW), .WAIT_STATES(WS)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .instr_read_in(instr_read_in),
    .instr_address_in(instr_address_in),
    .invalidate_in(invalidate_in),
    .instr_read_value_out(instr_read_value_out),
    .instr_fault_out(instr_fault_out),
    .instr_stall_out(instr_stall_out),
    .mem_en_out(mem_en_out),
    .mem_addr_out(mem_addr_out),
    .mem_rdata_in(mem_rdata_in)
`ifdef RV32_INSTR_RESP_STATS_EN
    ,
    .stat_hits_out(stat_hits_out),
    .stat_misses_out(stat_misses_out),
    .stat_faults_out(stat_faults_out)
`endif
  );

  // Synchronous memory: data valid 1+WS cycles after the enable
  logic [31:0] mem [SIZE];
  int unsigned lat = 0;
  logic [AW-1:0] raddr = '0;
  always @(posedge clk) begin
    if (mem_en_out) begin
      lat <= WS;
      raddr <= mem_addr_out;
    end else if (lat != 0) begin
      lat <= lat - 1;
    end
  end
  assign mem_rdata_in = (lat == 0) ? mem[raddr] : 32'hDEAD_BEEF;

  typedef struct {
    logic [31:0] value;
    logic fault;
    logic stall;
    logic en;
    logic [AW-1:0] maddr;
    logic [31:0] hits;
    logic [31:0] misses;
    logic [31:0] faults;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  // Model: hold entry plus at most one in-flight fetch with a deadline
  bit h_valid = 0;
  logic [31:0] h_addr = '0, h_data = '0;
  bit f_active = 0, f_killed = 0;
  logic [31:0] f_addr = '0;
  int cyc = 0, f_done = 0;
  int unsigned st_h = 0, st_m = 0, st_f = 0;

  function automatic longint off_of(logic [31:0] a);
    return longint'({32'd0, a}) - longint'({32'd0, BASE});
  endfunction

  function automatic bit is_fault(logic [31:0] a);
    longint o = off_of(a);
    return (a % 4 != 0) || (o < 0) || (o >= 4 * SIZE);
  endfunction

  function automatic int idx_of(logic [31:0] a);
    return int'(off_of(a) / 4);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle-time %0t got %h want %h",
               name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() != 0) begin
      e = sbq.pop_front();
      check("value", instr_read_value_out, e.value);
      check("fault", 32'(instr_fault_out), 32'(e.fault));
      check("stall", 32'(instr_stall_out), 32'(e.stall));
      check("mem_en", 32'(mem_en_out), 32'(e.en));
      if (e.en) check("mem_addr", 32'(mem_addr_out), 32'(e.maddr));
`ifdef RV32_INSTR_RESP_STATS_EN
      check("stat_hits", stat_hits_out, e.hits);
      check("stat_misses", stat_misses_out, e.misses);
      check("stat_faults", stat_faults_out, e.faults);
`endif
    end
  end

  task automatic step(bit rd, logic [31:0] a, bit inv, bit rn);
    exp_t e;
    bit flt, hit, en;
    instr_read_in = rd;
    instr_address_in = a;
    invalidate_in = inv;
    reset_n = rn;
    flt = rn && rd && is_fault(a);
    hit = h_valid && (a == h_addr);
    en = rn && rd && !flt && !hit && !f_active;
    e.value = (rn && rd && !flt && hit) ? h_data : NOP;
    e.fault = flt;
    e.stall = rd && (!rn || (!flt && !hit));
    e.en = en;
    e.maddr = AW'(idx_of(a));
    e.hits = st_h;
    e.misses = st_m;
    e.faults = st_f;
    sbq.push_back(e);
    @(posedge clk);
    if (!rn) begin
      h_valid = 0;
      f_active = 0;
      f_killed = 0;
      st_h = 0;
      st_m = 0;
      st_f = 0;
    end else begin
      if (rd && !flt && hit) st_h++;
      if (en) st_m++;
      if (flt) st_f++;
      if (f_active) begin
        if (cyc == f_done) begin
          h_valid = !f_killed;
          h_addr = f_addr;
          h_data = mem[idx_of(f_addr)];
          f_active = 0;
        end else if (inv) begin
          f_killed = 1;
        end
      end
      if (en) begin
        f_active = 1;
        f_killed = 0;
        f_addr = a;
        f_done = cyc + 1 + WS;
      end
      if (inv) h_valid = 0;
    end
    cyc++;
    #1;
  endtask

  logic [31:0] pool [8];
  logic [31:0] cur;

  initial begin
    int r;
    for (int i = 0; i < SIZE; i++) mem[i] = $urandom;
    mem[0] = 32'h0000_0297;
    pool[0] = 32'h0;  pool[1] = 32'h4;  pool[2] = 32'h8;
    pool[3] = 32'h10; pool[4] = 32'h40; pool[5] = 32'hFFC;
    pool[6] = 32'h20; pool[7] = 32'h100;
    instr_read_in = 0;
    instr_address_in = 0;
    invalidate_in = 0;
    reset_n = 0;
    @(posedge clk);
    #1;
    step(0, 32'h0, 0, 0);
    step(1, 32'h0, 0, 0);
    for (int i = 0; i < 9; i++) step(1, 32'h0, 0, 1);
    step(1, 32'h2, 0, 1);
    step(1, 32'h1000, 0, 1);
    step(1, 32'h10, 0, 1);
    for (int i = 0; i < 8; i++) step(1, 32'h40, 0, 1);
    step(1, 32'h20, 0, 1);
    step(1, 32'h20, 1, 1);
    for (int i = 0; i < 8; i++) step(1, 32'h20, 0, 1);
    step(1, 32'h60, 0, 1);
    step(1, 32'h60, 0, 1);
    step(1, 32'h60, 1, 1);
    for (int i = 0; i < 6; i++) step(1, 32'h60, 0, 1);
    step(1, 32'h30, 0, 1);
    step(0, 32'h30, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 32'h8, 0, 1);
    step(0, 32'h8, 0, 1);
    cur = 32'h0;
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(99);
      if (r < 35) cur = cur;
      else if (r < 70) cur = pool[$urandom_range(7)];
      else if (r < 85) cur = {20'd0, 10'($urandom_range(SIZE - 1)), 2'b00};
      else if (r < 92) cur = $urandom;
      else cur = {20'd0, 10'($urandom_range(SIZE - 1)), 2'($urandom_range(1, 3))};
      step($urandom_range(9) != 0, cur,
           $urandom_range(29) == 0, $urandom_range(99) != 0);
    end
    @(negedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d want 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
